prog_loader: RTL and testbench

- Front-panel program loader that sits directly upstream of the program memory feeding the 16-bit processor.
- The operator enters each instruction word as two bytes on SW[7:0], confirming each byte with a KEY press.
- The block writes each completed word to consecutive program-memory addresses starting at 0.
- While loading, the processor is held in reset; a second KEY releases it to run the loaded program.

---
 rtl/prog_loader.sv | 163 ++++++++++++++++
 tb/tb_prog_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: front-panel program loader for the 16-bit processor.
// The operator enters each instruction word as two bytes on sw, confirming
// each byte with key_next_n. Completed words are written to consecutive
// program-memory addresses from 0. The processor is held in reset while
// loading; key_run_n (or filling the memory) releases it.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   sw[7:0]              byte value from the switches (sampled on key event)
//   key_next_n           "byte enter" push-button, active-low, asynchronous
//   key_run_n            "run" push-button, active-low, asynchronous
//   prog_we              one-cycle program-memory write strobe
//   prog_addr, prog_data write address/data, valid with prog_we and held after
//   cpu_rst              active-high reset to the processor
//   loading              high in every state except RUN
//   byte_sel             0 = expecting high byte, 1 = expecting low byte
//   word_count           words written since reset, 0..2^ADDR_W

// Key conditioning: two-flop synchronizer, debouncer, press-event pulse.
//   press  one-cycle pulse in the cycle after the debounced level falls
module prog_loader_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1, sync2;
    logic             stable, stable_d;
    logic [CNT_W-1:0] cnt;

    // The counter runs only while the synchronized level disagrees with the
    // accepted level, so a new level is adopted after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any return to the old level restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            sync1    <= key_n;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Only the 1->0 (press) transition produces an event.
    assign press = stable_d & ~stable;
endmodule

module prog_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned ADDR_W          = 8,
    parameter int unsigned DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sw,
    input  logic              key_next_n,
    input  logic              key_run_n,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_rst,
    output logic              loading,
    output logic              byte_sel,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [1:0] LOAD_HI = 2'd0;
    localparam logic [1:0] LOAD_LO = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] RUN     = 2'd3;

    logic              next_evt, run_evt;
    logic [1:0]        state;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] addr;

    prog_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_next_n),
        .press (next_evt)
    );

    prog_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_run_n),
        .press (run_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD_HI;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            hi_byte    <= '0;
            addr       <= '0;
            word_count <= '0;
            cpu_rst    <= 1'b1;
            loading    <= 1'b1;
            byte_sel   <= 1'b0;
        end else begin
            case (state)
                LOAD_HI: begin
                    // Run has priority; a simultaneous next press is dropped.
                    if (run_evt) begin
                        state <= RUN;
                    end else if (next_evt) begin
                        hi_byte  <= sw;
                        byte_sel <= 1'b1;
                        state    <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (run_evt) begin
                        // Pending high byte is discarded, nothing is written.
                        byte_sel <= 1'b0;
                        state    <= RUN;
                    end else if (next_evt) begin
                        prog_data <= {hi_byte, sw};
                        prog_addr <= addr;
                        prog_we   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    prog_we    <= 1'b0;
                    word_count <= word_count + (ADDR_W + 1)'(1);
                    byte_sel   <= 1'b0;
                    // A run press during the write takes effect once it is done;
                    // a full memory ends loading without wrapping the address.
                    if (run_evt || addr == '1) begin
                        state <= RUN;
                    end else begin
                        addr  <= addr + ADDR_W'(1);
                        state <= LOAD_HI;
                    end
                end
                RUN: begin
                    cpu_rst <= 1'b0;
                    loading <= 1'b0;
                end
                default: state <= LOAD_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sw = 8'h00;
    logic        key_next_n = 1'b1;
    logic        key_run_n = 1'b1;

    logic        a_we, a_cpu_rst, a_loading, a_byte_sel;
    logic [7:0]  a_addr;
    logic [15:0] a_data;
    logic [8:0]  a_wc;

    logic        b_we, b_cpu_rst, b_loading, b_byte_sel;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic [2:0]  b_wc;

    always #5 clk = ~clk;

    prog_loader #(.DEBOUNCE_CYCLES(4), .ADDR_W(8), .DATA_W(16)) dut_a (
        .clk(clk), .rst(rst), .sw(sw), .key_next_n(key_next_n), .key_run_n(key_run_n),
        .prog_we(a_we), .prog_addr(a_addr), .prog_data(a_data), .cpu_rst(a_cpu_rst),
        .loading(a_loading), .byte_sel(a_byte_sel), .word_count(a_wc)
    );

    prog_loader #(.DEBOUNCE_CYCLES(4), .ADDR_W(2), .DATA_W(16)) dut_b (
        .clk(clk), .rst(rst), .sw(sw), .key_next_n(key_next_n), .key_run_n(key_run_n),
        .prog_we(b_we), .prog_addr(b_addr), .prog_data(b_data), .cpu_rst(b_cpu_rst),
        .loading(b_loading), .byte_sel(b_byte_sel), .word_count(b_wc)
    );

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_data;
        logic [7:0]  exp_addr;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    vec_t vecs[4];
    wr_t  qa[$];
    wr_t  qb[$];
    int   checks = 0;
    int   errors = 0;

    // Every sampled cycle with the strobe high is recorded, so a strobe wider
    // than one cycle shows up as extra entries.
    always @(negedge clk) begin
        if (!rst && a_we) qa.push_back('{a_addr, a_data});
        if (!rst && b_we) qb.push_back('{{6'b0, b_addr}, b_data});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        qa.delete();
        qb.delete();
        cycles(1);
    endtask

    task automatic press_next(input logic [7:0] b);
        sw = b;
        key_next_n = 1'b0;
        cycles(10);
        key_next_n = 1'b1;
        cycles(10);
    endtask

    task automatic press_run();
        key_run_n = 1'b0;
        cycles(10);
        key_run_n = 1'b1;
        cycles(10);
    endtask

    task automatic glitch(input int n);
        key_next_n = 1'b0;
        cycles(n);
        key_next_n = 1'b1;
        cycles(12);
    endtask

    initial begin
        vecs[0] = '{8'h10, 8'h05, 16'h1005, 8'h00};
        vecs[1] = '{8'h41, 8'h00, 16'h4100, 8'h01};
        vecs[2] = '{8'hD0, 8'h00, 16'hD000, 8'h02};
        vecs[3] = '{8'h7E, 8'h81, 16'h7E81, 8'h03};

        // Reset state
        do_reset();
        chk("rst_we", a_we, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_data", a_data, 0);
        chk("rst_wc", a_wc, 0);
        chk("rst_cpu_rst", a_cpu_rst, 1);
        chk("rst_loading", a_loading, 1);
        chk("rst_byte_sel", a_byte_sel, 0);

        // Short glitches are filtered; a held press gives one event
        glitch(1);
        chk("glitch1_byte_sel", a_byte_sel, 0);
        glitch(2);
        chk("glitch2_byte_sel", a_byte_sel, 0);
        press_next(8'h55);
        chk("press_byte_sel", a_byte_sel, 1);
        chk("press_no_write", qa.size(), 0);

        // Single word 0x1234
        do_reset();
        press_next(8'h12);
        chk("w1_byte_sel_mid", a_byte_sel, 1);
        press_next(8'h34);
        chk("w1_nwrites", qa.size(), 1);
        if (qa.size() >= 1) begin
            chk("w1_addr", qa[0].addr, 8'h00);
            chk("w1_data", qa[0].data, 16'h1234);
        end
        chk("w1_hold_data", a_data, 16'h1234);
        chk("w1_we_low", a_we, 0);
        chk("w1_wc", a_wc, 1);
        chk("w1_byte_sel", a_byte_sel, 0);
        chk("w1_cpu_rst", a_cpu_rst, 1);

        // Three words then run
        do_reset();
        for (int i = 0; i < 3; i++) begin
            press_next(vecs[i].hi);
            press_next(vecs[i].lo);
        end
        press_run();
        chk("w3_nwrites", qa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (qa.size() > i) begin
                chk($sformatf("w3_addr%0d", i), qa[i].addr, vecs[i].exp_addr);
                chk($sformatf("w3_data%0d", i), qa[i].data, vecs[i].exp_data);
            end
        end
        chk("w3_wc", a_wc, 3);
        chk("w3_cpu_rst", a_cpu_rst, 0);
        chk("w3_loading", a_loading, 0);
        press_next(8'h99);
        press_next(8'h88);
        chk("w3_run_ignores_next", qa.size(), 3);
        chk("w3_still_run", a_cpu_rst, 0);

        // High byte then run: discarded
        do_reset();
        press_next(8'hAB);
        press_run();
        chk("abort_nwrites", qa.size(), 0);
        chk("abort_wc", a_wc, 0);
        chk("abort_loading", a_loading, 0);
        chk("abort_cpu_rst", a_cpu_rst, 0);

        // Run and next together: run wins
        do_reset();
        sw = 8'h77;
        key_next_n = 1'b0;
        key_run_n = 1'b0;
        cycles(10);
        key_next_n = 1'b1;
        key_run_n = 1'b1;
        cycles(10);
        chk("both_loading", a_loading, 0);
        chk("both_byte_sel", a_byte_sel, 0);
        chk("both_nwrites", qa.size(), 0);

        // ADDR_W=2 fills after 4 words and runs by itself
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press_next(vecs[i].hi);
            press_next(vecs[i].lo);
        end
        chk("full_nwrites", qb.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (qb.size() > i) begin
                chk($sformatf("full_addr%0d", i), qb[i].addr, vecs[i].exp_addr);
                chk($sformatf("full_data%0d", i), qb[i].data, vecs[i].exp_data);
            end
        end
        chk("full_wc", b_wc, 4);
        chk("full_cpu_rst", b_cpu_rst, 0);
        chk("full_loading", b_loading, 0);
        chk("full_a_cpu_rst", a_cpu_rst, 1);
        chk("full_a_wc", a_wc, 4);

        // Reset mid-word after 2 words
        do_reset();
        for (int i = 0; i < 2; i++) begin
            press_next(vecs[i].hi);
            press_next(vecs[i].lo);
        end
        press_next(8'hCC);
        chk("mid_byte_sel_pre", a_byte_sel, 1);
        chk("mid_wc_pre", a_wc, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        qa.delete();
        chk("mid_addr", a_addr, 0);
        chk("mid_wc", a_wc, 0);
        chk("mid_cpu_rst", a_cpu_rst, 1);
        chk("mid_byte_sel", a_byte_sel, 0);
        press_next(8'hBE);
        press_next(8'hEF);
        chk("mid_nwrites", qa.size(), 1);
        if (qa.size() >= 1) begin
            chk("mid_next_addr", qa[0].addr, 8'h00);
            chk("mid_next_data", qa[0].data, 16'hBEEF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
